// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: key length, S memory depth, byte type, KSA states.
// No logic; types and constants only.
// Imported by the key-scheduling stage.
package arc4_pkg;

  localparam int KEY_BYTES = 3;
  localparam int S_DEPTH   = 256;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    WT_I,
    RD_J,
    WT_J,
    WR_I,
    WR_J
  } ksa_state_t;

endpackage

// File: rtl/ksa.sv
// ARC4 key schedule over an identity-preloaded S memory (single-port sync RAM).
// Latency: 6 cycles per iteration, 1536 cycles from accept edge to rdy.
// Backpressure: en is only honoured while rdy=1 (or on the final edge of a run); busy en is dropped.
module ksa
  import arc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  addr,
  input  logic [7:0]  rddata,
  output logic [7:0]  wrdata,
  output logic        wren
);

  localparam byte_t      LAST_I   = byte_t'(S_DEPTH - 1);
  localparam logic [1:0] LAST_KIX = 2'(KEY_BYTES - 1);

  ksa_state_t  state_q, state_d;
  byte_t       i_q, i_d;
  byte_t       j_q, j_d;
  byte_t       si_q, si_d;
  byte_t       sj_q, sj_d;
  logic [23:0] kreg_q, kreg_d;
  logic [1:0]  kidx_q, kidx_d;
  byte_t       addr_q, addr_d;
  byte_t       wrdata_q, wrdata_d;
  logic        wren_q, wren_d;
  byte_t       key_byte;

  // Key byte for the current i: byte 0 is the most significant key byte.
  always_comb begin
    key_byte = kreg_q[7:0];
    case (kidx_q)
      2'd0:    key_byte = kreg_q[23:16];
      2'd1:    key_byte = kreg_q[15:8];
      default: key_byte = kreg_q[7:0];
    endcase
  end

  // Iteration sequencing plus next-cycle memory port values, so every output is a flop.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    sj_d     = sj_q;
    kreg_d   = kreg_q;
    kidx_d   = kidx_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RD_I;
          kreg_d  = key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
        end
      end
      RD_I: state_d = WT_I;
      WT_I: begin
        si_d    = rddata;
        j_d     = j_q + rddata + key_byte;
        state_d = RD_J;
      end
      RD_J: state_d = WT_J;
      WT_J: begin
        sj_d    = rddata;
        state_d = WR_I;
      end
      WR_I: state_d = WR_J;
      WR_J: begin
        i_d    = i_q + 8'd1;
        kidx_d = (kidx_q == LAST_KIX) ? 2'd0 : kidx_q + 2'd1;
        if (i_q != LAST_I) begin
          state_d = RD_I;
        end else if (en) begin
          // Completion edge doubles as the earliest accept edge for a held en.
          state_d = RD_I;
          kreg_d  = key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Memory port for the state being entered; addr/wrdata hold elsewhere.
    case (state_d)
      RD_I: addr_d = i_d;
      RD_J: addr_d = j_d;
      WR_I: begin
        addr_d   = i_d;
        wrdata_d = sj_d;
        wren_d   = 1'b1;
      end
      WR_J: begin
        addr_d   = j_d;
        wrdata_d = si_d;
        wren_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset clears wren at once so no stray write follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      kreg_q   <= '0;
      kidx_q   <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      kreg_q   <= kreg_d;
      kidx_q   <= kidx_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
    end
  end

  assign rdy    = (state_q == IDLE);
  assign addr   = addr_q;
  assign wrdata = wrdata_q;
  assign wren   = wren_q;

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: S memory model, table of partial-schedule vectors,
// randomized full runs against an array-based ARC4 key-schedule model,
// plus reset, busy-en, and back-to-back sequences.
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem  [256];
  logic [7:0] gold [256];
  int         wr_cnt = 0;
  logic [7:0] wq_a [$];
  logic [7:0] wq_d [$];

  always #5 clk = ~clk;

  ksa dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  // Synchronous single-port RAM, read-first.
  always @(posedge clk) begin
    rddata <= mem[addr];
    if (wren) begin
      mem[addr] = wrdata;
      wq_a.push_back(addr);
      wq_d.push_back(wrdata);
      wr_cnt = wr_cnt + 1;
    end
  end

  typedef struct {
    logic [23:0] key;
    int          iters;
    logic [7:0]  a;
    logic [7:0]  s;
    logic [7:0]  j;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ARC4 key schedule applied in place on gold[].
  task automatic ref_ksa(input logic [23:0] k);
    int jj;
    logic [7:0] kb;
    logic [7:0] t;
    jj = 0;
    for (int ii = 0; ii < 256; ii++) begin
      case (ii % 3)
        0:       kb = k[23:16];
        1:       kb = k[15:8];
        default: kb = k[7:0];
      endcase
      jj = (jj + int'(gold[ii]) + int'(kb)) % 256;
      t        = gold[ii];
      gold[ii] = gold[jj];
      gold[jj] = t;
    end
  endtask

  function automatic int count_mismatch();
    int n;
    n = 0;
    for (int ii = 0; ii < 256; ii++) if (mem[ii] !== gold[ii]) n++;
    return n;
  endfunction

  function automatic int count_missing();
    logic [255:0] seen;
    int n;
    seen = '0;
    n = 0;
    for (int ii = 0; ii < 256; ii++) seen[mem[ii]] = 1'b1;
    for (int ii = 0; ii < 256; ii++) if (!seen[ii]) n++;
    return n;
  endfunction

  task automatic init_mem();
    @(negedge clk);
    for (int ii = 0; ii < 256; ii++) begin
      mem[ii]  = 8'(ii);
      gold[ii] = 8'(ii);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents en for one edge (the accept edge E0) and returns 1 time unit after it.
  task automatic start(input logic [23:0] k);
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  // Counts edges after E0 until rdy is seen high; optionally pulses en while busy.
  task automatic run_busy(output int k, input int pulse_at);
    k = 0;
    while (k < 4000) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == pulse_at) en = 1'b1;
      else if (k == pulse_at + 1) en = 1'b0;
      if (rdy) break;
    end
  endtask

  task automatic full_run(input string tag, input logic [23:0] k, input int pulse_at);
    int busy;
    int base;
    init_mem();
    base = wr_cnt;
    start(k);
    run_busy(busy, pulse_at);
    ref_ksa(k);
    check({tag, " busy cycles"}, busy, 1536);
    check({tag, " write count"}, wr_cnt - base, 512);
    check({tag, " S mismatches vs model"}, count_mismatch(), 0);
    check({tag, " S missing values"}, count_missing(), 0);
  endtask

  initial begin
    int busy;
    int base;
    int base2;
    logic [23:0] k1;
    logic [23:0] k2;

    vecs[0] = '{key: 24'h00033C, iters: 2, a: 8'h01, s: 8'h04, j: 8'h04};
    vecs[1] = '{key: 24'h00033C, iters: 2, a: 8'h04, s: 8'h01, j: 8'h04};
    vecs[2] = '{key: 24'h00033C, iters: 3, a: 8'h02, s: 8'h42, j: 8'h42};
    vecs[3] = '{key: 24'h00033C, iters: 3, a: 8'h42, s: 8'h02, j: 8'h42};
    vecs[4] = '{key: 24'h000000, iters: 1, a: 8'h00, s: 8'h00, j: 8'h00};
    vecs[5] = '{key: 24'h000000, iters: 2, a: 8'h01, s: 8'h01, j: 8'h01};
    vecs[6] = '{key: 24'h000000, iters: 3, a: 8'h02, s: 8'h03, j: 8'h03};
    vecs[7] = '{key: 24'h000000, iters: 3, a: 8'h03, s: 8'h02, j: 8'h03};

    rst_n = 1'b0;
    en    = 1'b0;
    key   = '0;
    for (int ii = 0; ii < 256; ii++) mem[ii] = 8'(ii);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset rdy", rdy, 1);
    check("reset wren", wren, 0);
    check("reset addr", addr, 0);
    rst_n = 1'b1;

    // Partial schedules from identity, checked after n iterations
    for (int v = 0; v < 8; v++) begin
      do_reset();
      init_mem();
      start(vecs[v].key);
      repeat (6 * vecs[v].iters) @(posedge clk);
      #1;
      check($sformatf("vec%0d S[%0h]", v, vecs[v].a), mem[vecs[v].a], vecs[v].s);
      check($sformatf("vec%0d j", v), dut.j_q, vecs[v].j);
    end

    // Iteration 0 with i=j=0: two writes of 0 to address 0
    do_reset();
    init_mem();
    base = wr_cnt;
    start(24'h00033C);
    repeat (6) @(posedge clk);
    #1;
    check("iter0 write count", wr_cnt - base, 2);
    if (wr_cnt - base >= 2) begin
      check("iter0 wr0 addr", wq_a[base], 0);
      check("iter0 wr0 data", wq_d[base], 0);
      check("iter0 wr1 addr", wq_a[base + 1], 0);
      check("iter0 wr1 data", wq_d[base + 1], 0);
    end

    // Full run with en pulsed mid-run (must be ignored)
    do_reset();
    full_run("key1E4600", 24'h1E4600, 300);

    // Reset mid-run, then a clean complete run
    do_reset();
    init_mem();
    start(24'hA5C3F0);
    repeat (700) @(posedge clk);
    #1;
    check("pre-reset wren", wren, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset mid-run wren", wren, 0);
    base2 = wr_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset rdy", rdy, 1);
    repeat (20) @(negedge clk);
    check("post-reset no writes", wr_cnt - base2, 0);
    full_run("after-reset", 24'h5A17E2, -10);

    // Randomized keys
    for (int r = 0; r < 3; r++) begin
      do_reset();
      full_run($sformatf("rand%0d", r), 24'($urandom), -10);
    end

    // Back-to-back: en held through completion, key changes before second accept
    do_reset();
    init_mem();
    k1   = 24'($urandom);
    k2   = 24'($urandom);
    base = wr_cnt;
    @(negedge clk);
    key = k1;
    en  = 1'b1;
    @(posedge clk);
    busy = 0;
    while (busy < 7000) begin
      @(posedge clk);
      busy++;
      @(negedge clk);
      if (busy == 100) key = k2;
      if (busy == 1536) en = 1'b0;
      if (rdy) break;
    end
    ref_ksa(k1);
    ref_ksa(k2);
    check("b2b busy cycles", busy, 3072);
    check("b2b write count", wr_cnt - base, 1024);
    check("b2b S mismatches vs model", count_mismatch(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
